// File: rtl/error_ek_pkg.sv
// Shared definitions for the error stage that feeds the integral-term block:
// default widths and latencies, FSM state encoding and a counter sizing helper.
package error_ek_pkg;

    // Signed sample width shared with the ADC interface and the ik block.
    localparam int N_DEF       = 18;

    // Default strobe latencies, counted in clock edges after the capture edge.
    // They line up with the three register stages inside ik.
    localparam int LAT_EN1_DEF = 2;
    localparam int LAT_EN2_DEF = 3;

    // IDLE waits for a sample, ESPERA walks through the strobe sequence.
    typedef enum logic {
        IDLE   = 1'b0,
        ESPERA = 1'b1
    } estado_t;

    // The sequence counter must reach LAT_EN2+1 without wrapping.
    function automatic int cnt_width(input int lat_en2);
        return $clog2(lat_en2 + 2);
    endfunction

endpackage

// File: rtl/error_ek_restador.sv
// Saturating signed subtractor: diferencia = clamp(a - b) to the N-bit range.
module restador_saturado
    import error_ek_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diferencia,
    output logic         sat
);

    logic [N:0]   dif_ext;
    logic [N-1:0] valor_max;
    logic [N-1:0] valor_min;

    // Subtract with one guard bit; a mismatch between the top two bits means
    // the exact result does not fit in N bits, so clamp toward its sign.
    always_comb begin
        dif_ext    = {a[N-1], a} - {b[N-1], b};
        valor_max  = {1'b0, {(N-1){1'b1}}};
        valor_min  = {1'b1, {(N-1){1'b0}}};
        diferencia = dif_ext[N-1:0];
        sat        = 1'b0;
        if (dif_ext[N] != dif_ext[N-1]) begin
            sat        = 1'b1;
            diferencia = dif_ext[N] ? valor_min : valor_max;
        end
    end

endmodule

// File: rtl/error_ek.sv
// Error stage ahead of the integral-term block: captures ek = ref - y on each
// accepted ADC sample, holds it steady and fires en1/en2 at fixed latencies so
// that ik accumulates exactly once per sample.
module error_ek
    import error_ek_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int LAT_EN1 = LAT_EN1_DEF,
    parameter int LAT_EN2 = LAT_EN2_DEF
) (
    input  logic         clk,
    // Active-low: 0 holds the block in reset.
    input  logic         reset,
    input  logic         habilitar,
    input  logic         adc_valido,
    input  logic [N-1:0] adc_dato,
    // Setpoint; "ref" is a reserved word in SystemVerilog, hence the suffix.
    input  logic [N-1:0] ref_i,
    output logic [N-1:0] ek,
    output logic         ek_valido,
    output logic         en1,
    output logic         en2,
    output logic         ocupado,
    output logic         sat,
    output logic         overrun
);

    localparam int            CW      = cnt_width(LAT_EN2);
    localparam logic [CW-1:0] CNT_UNO = CW'(1);
    localparam logic [CW-1:0] CNT_EN1 = CW'(LAT_EN1);
    localparam logic [CW-1:0] CNT_EN2 = CW'(LAT_EN2);
    localparam logic [CW-1:0] CNT_FIN = CW'(LAT_EN2 + 1);

    estado_t       estado_q, estado_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [N-1:0]  ek_q, ek_d;
    logic          sat_q, sat_d;
    logic          ek_valido_q, ek_valido_d;
    logic          en1_q, en1_d;
    logic          en2_q, en2_d;
    logic          ocupado_q, ocupado_d;
    logic          overrun_q, overrun_d;

    logic [N-1:0]  diferencia;
    logic          dif_sat;

    logic          fin_secuencia;
    logic          captura;
    logic          descarte;

    restador_saturado #(
        .N(N)
    ) u_restador (
        .a         (ref_i),
        .b         (adc_dato),
        .diferencia(diferencia),
        .sat       (dif_sat)
    );

    // Classify this edge: end of a sequence, an accepted sample, or a sample
    // that arrives too early and must be dropped. A sample on the closing edge
    // of a sequence is accepted, giving back-to-back operation.
    always_comb begin
        fin_secuencia = (estado_q == ESPERA) && (cnt_q == CNT_FIN);
        captura       = habilitar && adc_valido &&
                        ((estado_q == IDLE) || fin_secuencia);
        descarte      = habilitar && adc_valido && !captura;
    end

    // State and sequence counter; reset aborts any sequence in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q <= IDLE;
            cnt_q    <= '0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next state: disabling wins over everything, then a capture restarts
    // the count at 1, otherwise ESPERA counts up until the closing edge.
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        if (!habilitar) begin
            estado_d = IDLE;
            cnt_d    = '0;
        end else if (captura) begin
            estado_d = ESPERA;
            cnt_d    = CNT_UNO;
        end else if (fin_secuencia) begin
            estado_d = IDLE;
            cnt_d    = '0;
        end else if (estado_q == ESPERA) begin
            cnt_d    = cnt_q + CNT_UNO;
        end
    end

    // Output next-values: ek/sat hold until the next capture, strobes are
    // single-cycle decodes of the counter, overrun is sticky until disabled.
    always_comb begin
        ek_d        = ek_q;
        sat_d       = sat_q;
        ek_valido_d = 1'b0;
        en1_d       = 1'b0;
        en2_d       = 1'b0;
        ocupado_d   = (estado_d == ESPERA);
        overrun_d   = overrun_q;
        if (!habilitar) begin
            ek_d      = '0;
            sat_d     = 1'b0;
            overrun_d = 1'b0;
        end else begin
            if (captura) begin
                ek_d        = diferencia;
                sat_d       = dif_sat;
                ek_valido_d = 1'b1;
            end
            if (descarte) begin
                overrun_d = 1'b1;
            end
            if (estado_q == ESPERA) begin
                en1_d = (cnt_q == CNT_EN1);
                en2_d = (cnt_q == CNT_EN2);
            end
        end
    end

    // Output registers; everything visible to ik comes straight from a flop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ek_q        <= '0;
            sat_q       <= 1'b0;
            ek_valido_q <= 1'b0;
            en1_q       <= 1'b0;
            en2_q       <= 1'b0;
            ocupado_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            ek_q        <= ek_d;
            sat_q       <= sat_d;
            ek_valido_q <= ek_valido_d;
            en1_q       <= en1_d;
            en2_q       <= en2_d;
            ocupado_q   <= ocupado_d;
            overrun_q   <= overrun_d;
        end
    end

    assign ek        = ek_q;
    assign sat       = sat_q;
    assign ek_valido = ek_valido_q;
    assign en1       = en1_q;
    assign en2       = en2_q;
    assign ocupado   = ocupado_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_error_ek.sv
// Bench for error_ek: a table of saturation vectors, hand-written sequences
// for the multi-cycle cases, and a random run against a timeline model.
module tb_error_ek;

    localparam int N    = 18;
    localparam int LAT1 = 2;
    localparam int LAT2 = 3;
    localparam int MAXV = (1 <<< (N - 1)) - 1;
    localparam int MINV = -(1 <<< (N - 1));

    logic         clk = 1'b0;
    logic         reset;
    logic         habilitar;
    logic         adc_valido;
    logic [N-1:0] adc_dato;
    logic [N-1:0] ref_i;
    logic [N-1:0] ek;
    logic         ek_valido;
    logic         en1;
    logic         en2;
    logic         ocupado;
    logic         sat;
    logic         overrun;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        int r;
        int a;
        int expEk;
        int expSat;
    } vec_t;

    vec_t tabla[7];

    error_ek #(
        .N      (N),
        .LAT_EN1(LAT1),
        .LAT_EN2(LAT2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .habilitar (habilitar),
        .adc_valido(adc_valido),
        .adc_dato  (adc_dato),
        .ref_i     (ref_i),
        .ek        (ek),
        .ek_valido (ek_valido),
        .en1       (en1),
        .en2       (en2),
        .ocupado   (ocupado),
        .sat       (sat),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    // Flag order: {ek_valido, en1, en2, ocupado, sat, overrun}
    function automatic int getFlags();
        return int'({ek_valido, en1, en2, ocupado, sat, overrun});
    endfunction

    function automatic int ekValue();
        return int'($signed(ek));
    endfunction

    // Exact difference clamped into the signed N-bit range.
    task automatic refError(input int r, input int a, output int e, output int s);
        int d;
        d = r - a;
        s = 0;
        e = d;
        if (d > MAXV) begin
            e = MAXV;
            s = 1;
        end else if (d < MINV) begin
            e = MINV;
            s = 1;
        end
    endtask

    function automatic int randData();
        int k;
        k = $urandom_range(0, 7);
        case (k)
            0: return MAXV;
            1: return MINV;
            2: return $urandom_range(0, 3) - 2;
            default: return int'($urandom_range(0, (1 << N) - 1)) + MINV;
        endcase
    endfunction

    task automatic applyStimulus(input bit hab, input bit val, input int r, input int a);
        habilitar  = hab;
        adc_valido = val;
        ref_i      = r[N-1:0];
        adc_dato   = a[N-1:0];
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    initial begin
        int cyc;
        int lastCap;
        int mEk;
        int mSat;
        int mOvr;
        int expFlags;
        int r;
        int a;
        bit hab;
        bit val;

        tabla[0] = '{131071, -5, 131071, 1};
        tabla[1] = '{-131072, 1, -131072, 1};
        tabla[2] = '{5, 3, 2, 0};
        tabla[3] = '{1000, 300, 700, 0};
        tabla[4] = '{-131072, 131071, -131072, 1};
        tabla[5] = '{131071, -131072, 131071, 1};
        tabla[6] = '{-7, 100, -107, 0};

        // Reset state
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 0, 0);
        #12;
        checkOutput("reset_ek", ekValue(), 0);
        checkOutput("reset_flags", getFlags(), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 0, 0);
        stepCycle();

        // Nominal sequence
        applyStimulus(1'b1, 1'b1, 1000, 300);
        stepCycle();
        checkOutput("nom_ek_E0", ekValue(), 700);
        checkOutput("nom_flags_E0", getFlags(), 'b100100);
        applyStimulus(1'b1, 1'b0, -1, 77);
        stepCycle();
        checkOutput("nom_flags_E1", getFlags(), 'b000100);
        stepCycle();
        checkOutput("nom_flags_E2", getFlags(), 'b010100);
        stepCycle();
        checkOutput("nom_flags_E3", getFlags(), 'b001100);
        stepCycle();
        checkOutput("nom_flags_E4", getFlags(), 'b000000);
        checkOutput("nom_ek_E4", ekValue(), 700);

        // Saturation table
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 1'b1, tabla[i].r, tabla[i].a);
            stepCycle();
            checkOutput($sformatf("tab%0d_ek", i), ekValue(), tabla[i].expEk);
            checkOutput($sformatf("tab%0d_sat", i), int'(sat), tabla[i].expSat);
            checkOutput($sformatf("tab%0d_valid", i), int'(ek_valido), 1);
            applyStimulus(1'b1, 1'b0, 0, 0);
            repeat (LAT2 + 1) stepCycle();
            checkOutput($sformatf("tab%0d_idle", i), int'(ocupado), 0);
            checkOutput($sformatf("tab%0d_hold", i), ekValue(), tabla[i].expEk);
        end

        // Overrun: early sample dropped, sticky flag, next sample at E4 accepted
        applyStimulus(1'b1, 1'b1, 1000, 300);
        stepCycle();
        applyStimulus(1'b1, 1'b1, 1000, 0);
        stepCycle();
        checkOutput("ovr_ek_E1", ekValue(), 700);
        checkOutput("ovr_flags_E1", getFlags(), 'b000101);
        applyStimulus(1'b1, 1'b0, 0, 0);
        stepCycle();
        checkOutput("ovr_flags_E2", getFlags(), 'b010101);
        stepCycle();
        checkOutput("ovr_flags_E3", getFlags(), 'b001101);
        applyStimulus(1'b1, 1'b1, 1000, 500);
        stepCycle();
        checkOutput("ovr_ek_E4", ekValue(), 500);
        checkOutput("ovr_flags_E4", getFlags(), 'b100101);
        applyStimulus(1'b1, 1'b0, 0, 0);
        repeat (4) stepCycle();
        checkOutput("ovr_sticky", getFlags(), 'b000001);
        applyStimulus(1'b0, 1'b0, 0, 0);
        stepCycle();
        checkOutput("ovr_clear_flags", getFlags(), 0);
        checkOutput("ovr_clear_ek", ekValue(), 0);

        // Back-to-back samples at E0 and E4
        applyStimulus(1'b1, 1'b1, 1000, 100);
        stepCycle();
        checkOutput("b2b_ek_E0", ekValue(), 900);
        applyStimulus(1'b1, 1'b0, 0, 0);
        repeat (3) stepCycle();
        applyStimulus(1'b1, 1'b1, 1000, 200);
        stepCycle();
        checkOutput("b2b_ek_E4", ekValue(), 800);
        checkOutput("b2b_flags_E4", getFlags(), 'b100100);
        applyStimulus(1'b1, 1'b0, 0, 0);
        stepCycle();
        checkOutput("b2b_flags_E5", getFlags(), 'b000100);
        stepCycle();
        checkOutput("b2b_flags_E6", getFlags(), 'b010100);
        stepCycle();
        checkOutput("b2b_flags_E7", getFlags(), 'b001100);
        stepCycle();
        checkOutput("b2b_flags_E8", getFlags(), 'b000000);

        // Mid-sequence asynchronous reset
        applyStimulus(1'b1, 1'b1, 1000, 300);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 0, 0);
        stepCycle();
        #2;
        reset = 1'b0;
        #1;
        checkOutput("rst_async_ek", ekValue(), 0);
        checkOutput("rst_async_flags", getFlags(), 0);
        stepCycle();
        checkOutput("rst_E2_flags", getFlags(), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        stepCycle();
        checkOutput("rst_after1_flags", getFlags(), 0);
        stepCycle();
        checkOutput("rst_after2_flags", getFlags(), 0);
        checkOutput("rst_after2_ek", ekValue(), 0);

        // Disable mid-sequence, then re-enable with a fresh sample
        applyStimulus(1'b1, 1'b1, 1000, 300);
        stepCycle();
        applyStimulus(1'b1, 1'b0, 0, 0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 0, 0);
        stepCycle();
        checkOutput("dis_ek_E2", ekValue(), 0);
        checkOutput("dis_flags_E2", getFlags(), 0);
        applyStimulus(1'b1, 1'b0, 0, 0);
        stepCycle();
        checkOutput("dis_flags_E3", getFlags(), 0);
        stepCycle();
        checkOutput("dis_flags_E4", getFlags(), 0);
        applyStimulus(1'b1, 1'b1, 50, 80);
        stepCycle();
        checkOutput("reen_ek", ekValue(), -30);
        checkOutput("reen_flags_E0", getFlags(), 'b100100);
        applyStimulus(1'b1, 1'b0, 0, 0);
        stepCycle();
        stepCycle();
        checkOutput("reen_flags_E2", getFlags(), 'b010100);
        stepCycle();
        checkOutput("reen_flags_E3", getFlags(), 'b001100);
        stepCycle();

        // Disable and sample on the same edge: no capture
        applyStimulus(1'b0, 1'b1, 400, 100);
        stepCycle();
        checkOutput("dis_win_ek", ekValue(), 0);
        checkOutput("dis_win_flags", getFlags(), 0);

        // Random run against a timeline model: a sample is taken when enabled
        // and at least LAT2+1 edges after the previous capture.
        cyc     = 0;
        lastCap = -1000;
        mEk     = 0;
        mSat    = 0;
        mOvr    = 0;
        for (int i = 0; i < 400; i++) begin
            hab = ($urandom_range(0, 19) != 0);
            val = ($urandom_range(0, 2) == 0);
            r   = randData();
            a   = randData();
            applyStimulus(hab, val, r, a);
            stepCycle();
            cyc++;
            if (!hab) begin
                lastCap = -1000;
                mEk     = 0;
                mSat    = 0;
                mOvr    = 0;
            end else if (val) begin
                if (cyc - lastCap >= LAT2 + 1) begin
                    lastCap = cyc;
                    refError(r, a, mEk, mSat);
                end else begin
                    mOvr = 1;
                end
            end
            expFlags = ((cyc == lastCap) ? 32 : 0)
                     + ((cyc - lastCap == LAT1) ? 16 : 0)
                     + ((cyc - lastCap == LAT2) ? 8 : 0)
                     + ((cyc - lastCap <= LAT2) ? 4 : 0)
                     + (mSat * 2)
                     + mOvr;
            checkOutput($sformatf("rnd%0d_ek", i), ekValue(), mEk);
            checkOutput($sformatf("rnd%0d_flags", i), getFlags(), expFlags);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/error_ek.md
Name: error_ek

Overview:
- Upstream stage of the integral-term block (ik): turns each ADC sample and the setpoint into the error ek, then sequences the integrator.
- On each accepted sample it computes ek = ref - adc_dato, saturated to N bits, and registers it.
- ek is held stable while the block issues the en1/en2 strobes at fixed latencies, so ik accumulates exactly once per sample.
- It sits between the ADC interface and ik; ek, en1 and en2 connect directly to the same-named ik ports.

Parameters:
- N, 18, data width of signed two's-complement samples; must equal `N.
- LAT_EN1, 2, clock edges from ek capture to en1 assertion.
- LAT_EN2, 3, clock edges from ek capture to en2 assertion; LAT_EN1 < LAT_EN2 and LAT_EN2 >= 2.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- habilitar  in  1  run enable for the control loop.
- adc_valido  in  1  one-cycle pulse: adc_dato is valid this cycle.
- adc_dato  in  N  signed measured value y.
- ref  in  N  signed setpoint; sampled only on the capture edge.
- ek  out  N  signed registered error to ik.
- ek_valido  out  1  one-cycle pulse, high in the cycle after capture.
- en1  out  1  one-cycle strobe to ik en1.
- en2  out  1  one-cycle strobe to ik en2 (loads the ik output register).
- ocupado  out  1  high while a sequence is in flight.
- sat  out  1  high while the current ek is saturated.
- overrun  out  1  sticky: a sample arrived while ocupado.

Behaviour:
- Reset (reset=0), immediate and asynchronous:
  - every output goes to 0, FSM goes to IDLE, counter clears;
  - a sequence in progress is aborted and no strobe is issued afterwards.
- FSM states: IDLE, ESPERA.
- IDLE, on an edge where adc_valido=1 and habilitar=1 (capture edge E0):
  - ek <= sat(ref - adc_dato); sat <= saturation flag; ek_valido <= 1;
  - cnt <= 1; state <= ESPERA; ocupado <= 1.
- ESPERA, on each edge:
  - cnt increments;
  - en1 is high for exactly the cycle between edges E(LAT_EN1) and E(LAT_EN1+1);
  - en2 is high for exactly the cycle between edges E(LAT_EN2) and E(LAT_EN2+1);
  - at edge E(LAT_EN2+1): state <= IDLE, ocupado <= 0.
  - Defaults give en1 in cycle E2–E3 and en2 in cycle E3–E4, matching the 3-register ik pipeline.
- Minimum sample spacing is LAT_EN2+1 cycles (4 by default). A capture is allowed on the same edge that returns the FSM to IDLE only if adc_valido is high on that edge.
- ek and sat stay constant from E0 until the next capture; ik's free-running registers therefore see a stable ek.
- Arithmetic and saturation:
  - the subtraction is done in N+1 bits;
  - a result > 2^(N-1)-1 clamps to 2^(N-1)-1, and a result < -2^(N-1) clamps to -2^(N-1); sat=1 when clamping occurs;
  - no wrap-around is allowed.
- Overrun: adc_valido=1 while ocupado=1 sets overrun=1. The sample is dropped and the current sequence is unaffected. overrun clears only on reset or when habilitar=0.
- habilitar=0, at the next edge:
  - state <= IDLE; ek <= 0; sat <= 0; overrun <= 0;
  - en1, en2, ek_valido and ocupado go to 0;
  - any pending strobe is cancelled, so ik holds its value.
- Simultaneous habilitar=0 and adc_valido=1: habilitar wins and there is no capture.

Decomposition:
- constantes.h holds `N and the FSM state encodings (`IDLE, `ESPERA).
- One combinational sub-module, restador_saturado: inputs a, b (N bits); outputs N-bit diferencia and a sat flag.
- The FSM, counter and output registers live in error_ek.

Test Plan:
- Nominal: habilitar=1, ref=1000, adc_dato=300, one adc_valido pulse. Expect:
  - ek=700 and ek_valido=1 the cycle after E0;
  - en1 high only in cycle E2–E3 and en2 only in cycle E3–E4;
  - ocupado low after E4; with ik attached, ik reads 700*7 truncated.
- Saturation: ref=131071, adc=-5 → ek=131071, sat=1. ref=-131072, adc=1 → ek=-131072, sat=1. ref=5, adc=3 → ek=2, sat=0.
- Overrun: a second adc_valido at E1 (adc=0) → ignored, ek stays 700, overrun=1 and stays 1; the next sample at E4 is accepted.
- Back-to-back: adc_valido at E0 and again at E4 → two full strobe sequences with no gap error and overrun=0.
- Mid-sequence reset: pull reset low between E1 and E2, release at E3 → all outputs 0 immediately, no en1/en2 pulses, FSM in IDLE.
- Disable: habilitar=0 at E1 → ek=0 after E2 and no en1/en2. Re-enable plus a new sample → normal sequence.
